// File: rtl/sn74_counter_if.sv
// Control/data bundle for the sn74_counter: load/clear/enable controls in, count value and carry out.
interface sn74_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clrb;
  logic             loadb;
  logic [WIDTH-1:0] d;
  logic             enp;
  logic             ent;
  logic             up_dn;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (output clrb, loadb, d, enp, ent, up_dn, input q, rco);
  modport slave  (input clrb, loadb, d, enp, ent, up_dn, output q, rco);
endinterface

// File: rtl/sn74_counter.sv
// 74xx161/169-style synchronous counter (clear > load > count > hold) with combinational ripple carry.
// Optional up/down counting is enabled by defining SN74_COUNTER_UPDN_EN; WIDTH must be 2..16.
module sn74_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           vss,
  input  logic           vdd,
  sn74_counter_if.slave  bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             count_up;
  logic             tc;

`ifdef SN74_COUNTER_UPDN_EN
  assign count_up = bus.up_dn;
  wire   unused_pins = &{1'b0, vss, vdd};
`else
  // Direction pin kept for pin compatibility; this build only counts up.
  assign count_up = 1'b1;
  wire   unused_pins = &{1'b0, vss, vdd, bus.up_dn};
`endif

  // Next-state selection in edge priority order.
  always_comb begin
    q_d = q_q;
    if (!bus.clrb) begin
      q_d = '0;
    end else if (!bus.loadb) begin
      q_d = bus.d;
    end else if (bus.enp && bus.ent) begin
      q_d = count_up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= WIDTH'(RESET_VAL);
    end else begin
      q_q <= q_d;
    end
  end

  // Carry looks at the present count only, so cascaded stages see it within the same cycle.
  assign tc      = count_up ? (q_q == '1) : (q_q == '0);
  assign bus.rco = bus.ent & tc;
  assign bus.q   = q_q;

endmodule

// File: tb/tb_sn74_counter.sv
// Self-checking bench for sn74_counter: vector table, corner sequences, cascade, wide-reset and random runs.
module tb_sn74_counter;

  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_c = 1'b1;
  logic rst_w = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_q;

  always #5 clock = ~clock;

  sn74_counter_if #(.WIDTH(4))  ifa ();
  sn74_counter_if #(.WIDTH(4))  ifc0 ();
  sn74_counter_if #(.WIDTH(4))  ifc1 ();
  sn74_counter_if #(.WIDTH(16)) ifw ();

  sn74_counter #(.WIDTH(4), .RESET_VAL(0)) dut_a (
    .clock(clock), .reset(rst_a), .vss(1'b0), .vdd(1'b1), .bus(ifa));
  sn74_counter #(.WIDTH(4), .RESET_VAL(0)) dut_c0 (
    .clock(clock), .reset(rst_c), .vss(1'b0), .vdd(1'b1), .bus(ifc0));
  sn74_counter #(.WIDTH(4), .RESET_VAL(0)) dut_c1 (
    .clock(clock), .reset(rst_c), .vss(1'b0), .vdd(1'b1), .bus(ifc1));
  sn74_counter #(.WIDTH(16), .RESET_VAL(32'hFFFE)) dut_w (
    .clock(clock), .reset(rst_w), .vss(1'b0), .vdd(1'b1), .bus(ifw));

  assign ifc1.ent = ifc0.rco;

  // Reference model: direction, next value and carry from the counter's rules.
  function automatic bit mdl_up(bit up);
`ifdef SN74_COUNTER_UPDN_EN
    return up;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int mdl_next(int q, bit clrb, bit loadb, int d, bit enp, bit ent, bit up, int w);
    int m;
    m = 1 << w;
    if (!clrb) return 0;
    if (!loadb) return d % m;
    if (enp && ent) return mdl_up(up) ? (q + 1) % m : (q + m - 1) % m;
    return q;
  endfunction

  function automatic bit mdl_rco(int q, bit ent, bit up, int w);
    return ent && (mdl_up(up) ? (q == (1 << w) - 1) : (q == 0));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input bit clrb, input bit loadb, input int d, input bit enp, input bit ent, input bit up);
    ifa.clrb  = clrb;
    ifa.loadb = loadb;
    ifa.d     = 4'(d);
    ifa.enp   = enp;
    ifa.ent   = ent;
    ifa.up_dn = up;
  endtask

  // One clocked step on dut_a, checked against the model.
  task automatic step_a(input string nm, input bit clrb, input bit loadb, input int d,
                        input bit enp, input bit ent, input bit up);
    drive_a(clrb, loadb, d, enp, ent, up);
    @(posedge clock);
    #1;
    m_q = mdl_next(m_q, clrb, loadb, d, enp, ent, up, 4);
    check({nm, "_q"}, 32'(ifa.q), 32'(m_q));
    check({nm, "_rco"}, 32'(ifa.rco), 32'(mdl_rco(m_q, ent, up, 4)));
  endtask

  typedef struct {
    bit clrb; bit loadb; int d; bit enp; bit ent; bit up;
    int exp_q; bit exp_rco;
  } vec_t;

  vec_t vecs[12];
  int   rco_hi;
  int   comb;
  bit   c, l, p, t, u, r;
  int   dd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1, 0, 12, 0, 0, 1, 12, 0};
    vecs[1]  = '{0, 0,  5, 1, 1, 1,  0, 0};
    vecs[2]  = '{1, 0, 15, 0, 1, 1, 15, 1};
    vecs[3]  = '{1, 1,  0, 0, 1, 1, 15, 1};
    vecs[4]  = '{1, 1,  0, 1, 0, 1, 15, 0};
    vecs[5]  = '{1, 1,  0, 1, 1, 1,  0, 0};
    vecs[6]  = '{1, 1,  0, 1, 1, 1,  1, 0};
    vecs[7]  = '{1, 0,  9, 1, 1, 1,  9, 0};
    vecs[8]  = '{0, 1,  3, 1, 1, 1,  0, 0};
    vecs[9]  = '{1, 0, 14, 1, 1, 1, 14, 0};
    vecs[10] = '{1, 1,  0, 1, 1, 1, 15, 1};
    vecs[11] = '{1, 1,  0, 1, 1, 1,  0, 0};

    drive_a(1, 1, 0, 0, 0, 1);
    ifc0.clrb = 1; ifc0.loadb = 1; ifc0.d = '0; ifc0.enp = 1; ifc0.ent = 1; ifc0.up_dn = 1;
    ifc1.clrb = 1; ifc1.loadb = 1; ifc1.d = '0; ifc1.enp = 1; ifc1.up_dn = 1;
    ifw.clrb = 1; ifw.loadb = 1; ifw.d = '0; ifw.enp = 1; ifw.ent = 1; ifw.up_dn = 1;
    #2;
    check("reset_q", 32'(ifa.q), 32'd0);
    check("reset_rco", 32'(ifa.rco), 32'd0);
    @(posedge clock); #1;
    rst_a = 1'b0;
    m_q = 0;

    // Vector table from a known q=0 start.
    for (int i = 0; i < 12; i++) begin
      drive_a(vecs[i].clrb, vecs[i].loadb, vecs[i].d, vecs[i].enp, vecs[i].ent, vecs[i].up);
      @(posedge clock); #1;
      check($sformatf("vec%0d_q", i), 32'(ifa.q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_rco", i), 32'(ifa.rco), 32'(vecs[i].exp_rco));
      m_q = vecs[i].exp_q;
    end

    // Async reset at q=9 with no clock edge, then held across an edge with a pending load.
    step_a("load9", 1, 0, 9, 0, 0, 1);
    drive_a(1, 0, 7, 1, 1, 1);
    rst_a = 1'b1;
    #1;
    check("async_rst_q", 32'(ifa.q), 32'd0);
    @(posedge clock); #1;
    check("rst_hold_q", 32'(ifa.q), 32'd0);
    drive_a(1, 1, 0, 1, 1, 1);
    rst_a = 1'b0;
    m_q = 0;
    rco_hi = 32'(ifa.rco);
    for (int i = 0; i < 17; i++) begin
      step_a("cnt17", 1, 1, 0, 1, 1, 1);
      rco_hi += 32'(ifa.rco);
    end
    check("cnt17_final_q", 32'(ifa.q), 32'd1);
    check("cnt17_rco_cycles", 32'(rco_hi), 32'd1);

    // Reset rising together with a clock edge while a load is pending.
    step_a("load9b", 1, 0, 9, 0, 0, 1);
    drive_a(1, 0, 3, 0, 0, 1);
    @(posedge clock);
    rst_a = 1'b1;
    #1;
    check("rst_edge_q", 32'(ifa.q), 32'd0);
    @(posedge clock); #1;
    rst_a = 1'b0;
    m_q = 0;

    // Down-direction request at q=0.
    step_a("clr", 0, 1, 0, 0, 0, 1);
    drive_a(1, 1, 0, 1, 1, 0);
    #1;
`ifdef SN74_COUNTER_UPDN_EN
    check("dn_rco", 32'(ifa.rco), 32'd1);
    @(posedge clock); #1;
    check("dn_q", 32'(ifa.q), 32'd15);
    m_q = 15;
`else
    check("dn_rco", 32'(ifa.rco), 32'd0);
    @(posedge clock); #1;
    check("dn_q", 32'(ifa.q), 32'd1);
    m_q = 1;
`endif

    // Randomized stimulus including occasional async resets.
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 7) != 0);
      l  = ($urandom_range(0, 5) != 0);
      dd = int'($urandom_range(0, 15));
      p  = 1'($urandom_range(0, 1));
      t  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 31) == 0);
      drive_a(c, l, dd, p, t, u);
      rst_a = r;
      #1;
      if (r) check("rand_async_rst_q", 32'(ifa.q), 32'd0);
      @(posedge clock); #1;
      m_q = r ? 0 : mdl_next(m_q, c, l, dd, p, t, u, 4);
      check("rand_q", 32'(ifa.q), 32'(m_q));
      check("rand_rco", 32'(ifa.rco), 32'(mdl_rco(m_q, t, u, 4)));
    end
    rst_a = 1'b0;

    // Two cascaded 4-bit stages count as one 8-bit counter.
    @(posedge clock); #1;
    rst_c = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clock); #1;
      comb = {24'd0, ifc1.q, ifc0.q};
      if (comb != i % 256 || i == 255) check("cascade_q", 32'(comb), 32'(i % 256));
    end
    @(posedge clock); #1;
    check("cascade_wrap_q", 32'({ifc1.q, ifc0.q}), 32'd0);

    // 16-bit stage with non-zero reset value.
    @(posedge clock); #1;
    check("w16_rst_q", 32'(ifw.q), 32'hFFFE);
    check("w16_rst_rco", 32'(ifw.rco), 32'd0);
    rst_w = 1'b0;
    @(posedge clock); #1;
    check("w16_q1", 32'(ifw.q), 32'hFFFF);
    check("w16_rco1", 32'(ifw.rco), 32'd1);
    @(posedge clock); #1;
    check("w16_q2", 32'(ifw.q), 32'h0000);
    check("w16_rco2", 32'(ifw.rco), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
